// File: rtl/regfile_dump_reader.sv
// Walks the general-purpose registers through a spare read port and streams
// each (index, value) pair over valid/ready for post-halt debug dumps.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              halted,
  input  logic              start,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start or a rising edge of halted
  // FETCH | rf_read_addr == idx, capture the read data this cycle
  // SEND  | word held on the output until the consumer takes it
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_d;
  logic [ADDR_W-1:0]   index_d;
  logic                valid_d, last_d, done_d, busy_d;
  logic                halted_q;
  logic                trig;

  assign trig = start | (halted & ~halted_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = rf_read_addr;
    valid_d = out_valid;
    data_d  = out_data;
    index_d = out_index;
    last_d  = out_last;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          idx_d   = '0;
          addr_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // Snapshot the register now so later writes cannot disturb a stalled word.
        data_d  = rf_read_data;
        index_d = idx_q;
        last_d  = (idx_q == LAST_IDX);
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (out_valid && out_ready) begin
          valid_d = 1'b0;
          if (out_last) begin
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            addr_d  = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      halted_q     <= 1'b0;
      rf_read_addr <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_index    <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      halted_q     <= halted;
      rf_read_addr <= addr_d;
      out_valid    <= valid_d;
      out_data     <= data_d;
      out_index    <= index_d;
      out_last     <= last_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule
